// File: rtl/alu_cmd_driver_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_cmd_driver_if
// Brief    : Command, ALU-side and response signals of alu_cmd_driver.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_cmd_driver_if #(
    parameter int WIDTH = 128
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       cmd_opcode;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic [4:0]       cmd_shift;
    logic [3:0]       cmd_tag;

    logic [3:0]       alu_opcode;
    logic [WIDTH-1:0] alu_input1;
    logic [WIDTH-1:0] alu_input2;
    logic [4:0]       alu_shiftValue;
    logic [WIDTH-1:0] alu_result;
    logic             alu_carry;
    logic             alu_zero;
    logic             alu_overflow;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic [2:0]       rsp_flags;
    logic [3:0]       rsp_tag;
    logic             rsp_err;

    logic             busy;
    logic [15:0]      ops_count;

    // master is the driver itself; slave is the sequencer/ALU side
    modport master (
        input  cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_shift, cmd_tag,
        input  alu_result, alu_carry, alu_zero, alu_overflow,
        input  rsp_ready,
        output cmd_ready,
        output alu_opcode, alu_input1, alu_input2, alu_shiftValue,
        output rsp_valid, rsp_result, rsp_flags, rsp_tag, rsp_err,
        output busy, ops_count
    );

    modport slave (
        output cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_shift, cmd_tag,
        output alu_result, alu_carry, alu_zero, alu_overflow,
        output rsp_ready,
        input  cmd_ready,
        input  alu_opcode, alu_input1, alu_input2, alu_shiftValue,
        input  rsp_valid, rsp_result, rsp_flags, rsp_tag, rsp_err,
        input  busy, ops_count
    );
endinterface
`default_nettype wire

// File: rtl/alu_cmd_driver.sv
`default_nettype none
// ============================================================================
// Module   : alu_cmd_driver
// Brief    : Queues ALU requests, drives one at a time onto a combinational
//            ALU, holds operands SETTLE cycles and returns result and flags.
// Revision : 1.0 - initial release
// ============================================================================
module alu_cmd_driver #(
    parameter int WIDTH      = 128,
    parameter int SETTLE     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input logic              clk,
    input logic              rst,
    alu_cmd_driver_if.master bus
);
    localparam int              c_aw        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int              c_ent_w     = 13 + 2 * WIDTH;
    localparam logic [c_aw:0]   c_depth     = (c_aw + 1)'(FIFO_DEPTH);
    localparam logic [c_aw:0]   c_cnt_one   = (c_aw + 1)'(1);
    localparam logic [c_aw-1:0] c_ptr_one   = c_aw'(1);
    localparam logic [3:0]      c_settle_ld = 4'(SETTLE - 1);
    localparam logic [3:0]      c_max_opc   = 4'd6;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_drive = 2'd1;
    localparam logic [1:0] c_st_resp  = 2'd2;

    logic [c_ent_w-1:0] r_mem [FIFO_DEPTH];
    logic [c_aw-1:0]    r_wr_ptr;
    logic [c_aw-1:0]    r_rd_ptr;
    logic [c_aw:0]      r_count;
    logic [c_aw:0]      w_count_next;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [3:0]         r_settle;

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_capture;
    logic               w_rsp_fire;
    logic               w_head_illegal;

    logic [3:0]         w_head_opc;
    logic [WIDTH-1:0]   w_head_a;
    logic [WIDTH-1:0]   w_head_b;
    logic [4:0]         w_head_shift;
    logic [3:0]         w_head_tag;

    logic [3:0]         r_alu_opcode;
    logic [WIDTH-1:0]   r_alu_input1;
    logic [WIDTH-1:0]   r_alu_input2;
    logic [4:0]         r_alu_shift;
    logic [WIDTH-1:0]   r_rsp_result;
    logic [2:0]         r_rsp_flags;
    logic [3:0]         r_rsp_tag;
    logic               r_rsp_err;
    logic               r_busy;
    logic [15:0]        r_ops_count;

    assign w_full  = (r_count == c_depth);
    assign w_empty = (r_count == '0);

    // cmd_ready never looks at a same-cycle pop, so a full FIFO always stalls
    assign bus.cmd_ready = !w_full && !rst;
    assign w_push        = bus.cmd_valid && bus.cmd_ready;
    assign w_rsp_fire    = (r_state == c_st_resp) && bus.rsp_ready;

    assign {w_head_opc, w_head_a, w_head_b, w_head_shift, w_head_tag} = r_mem[r_rd_ptr];
    assign w_head_illegal = (w_head_opc > c_max_opc);

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = w_head_illegal ? c_st_resp : c_st_drive;
                end
            end
            c_st_drive: begin
                if (r_settle == 4'd0) begin
                    w_capture    = 1'b1;
                    w_state_next = c_st_resp;
                end
            end
            c_st_resp: begin
                if (w_rsp_fire) begin
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_state_next = w_head_illegal ? c_st_resp : c_st_drive;
                    end else begin
                        w_state_next = c_st_idle;
                    end
                end
            end
            default: w_state_next = c_st_idle;
        endcase
    end

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + c_cnt_one;
            2'b01:   w_count_next = r_count - c_cnt_one;
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {bus.cmd_opcode, bus.cmd_a, bus.cmd_b, bus.cmd_shift, bus.cmd_tag};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            r_count <= w_count_next;
        end
    end

    // ALU inputs move only on a legal pop, keeping them steady through RESP
    always_ff @(posedge clk) begin
        if (rst) begin
            r_alu_opcode <= '0;
            r_alu_input1 <= '0;
            r_alu_input2 <= '0;
            r_alu_shift  <= '0;
            r_settle     <= '0;
            r_rsp_result <= '0;
            r_rsp_flags  <= '0;
            r_rsp_tag    <= '0;
            r_rsp_err    <= 1'b0;
            r_busy       <= 1'b0;
            r_ops_count  <= '0;
        end else begin
            if (w_pop) begin
                r_rsp_tag <= w_head_tag;
                if (w_head_illegal) begin
                    r_rsp_result <= '0;
                    r_rsp_flags  <= '0;
                    r_rsp_err    <= 1'b1;
                end else begin
                    r_alu_opcode <= w_head_opc;
                    r_alu_input1 <= w_head_a;
                    r_alu_input2 <= w_head_b;
                    r_alu_shift  <= w_head_shift;
                    r_settle     <= c_settle_ld;
                end
            end else if ((r_state == c_st_drive) && (r_settle != 4'd0)) begin
                r_settle <= r_settle - 4'd1;
            end
            if (w_capture) begin
                r_rsp_result <= bus.alu_result;
                r_rsp_flags  <= {bus.alu_overflow, bus.alu_zero, bus.alu_carry};
                r_rsp_err    <= 1'b0;
            end
            if (w_rsp_fire) begin
                r_ops_count <= r_ops_count + 16'd1;
            end
            r_busy <= (w_state_next != c_st_idle) || (w_count_next != '0);
        end
    end

    assign bus.alu_opcode     = r_alu_opcode;
    assign bus.alu_input1     = r_alu_input1;
    assign bus.alu_input2     = r_alu_input2;
    assign bus.alu_shiftValue = r_alu_shift;
    assign bus.rsp_valid      = (r_state == c_st_resp);
    assign bus.rsp_result     = r_rsp_result;
    assign bus.rsp_flags      = r_rsp_flags;
    assign bus.rsp_tag        = r_rsp_tag;
    assign bus.rsp_err        = r_rsp_err;
    assign bus.busy           = r_busy;
    assign bus.ops_count      = r_ops_count;
endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_cmd_driver
// Brief    : Randomized self-checking bench for alu_cmd_driver (SETTLE 1 and 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_cmd_driver;
    localparam int WIDTH = 128;

    typedef struct {
        logic [3:0]       opc;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [4:0]       sh;
        logic [3:0]       tag;
    } cmd_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   exp_ops1 = 0;
    cmd_t last1;

    always #5 clk = ~clk;

    alu_cmd_driver_if #(.WIDTH(WIDTH)) bus1 ();
    alu_cmd_driver_if #(.WIDTH(WIDTH)) bus4 ();

    alu_cmd_driver #(.WIDTH(WIDTH), .SETTLE(1), .FIFO_DEPTH(4)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    alu_cmd_driver #(.WIDTH(WIDTH), .SETTLE(4), .FIFO_DEPTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

    // Behavioural ALU: returns {overflow, zero, carry, result}
    function automatic logic [WIDTH+2:0] alu_model(input logic [3:0] opc, input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b, input logic [4:0] sh);
        logic [2*WIDTH-1:0] rot;
        logic [WIDTH-1:0]   res;
        res = '0;
        rot = '0;
        case (opc)
            4'd0: begin rot = {a, a} << sh; res = rot[2*WIDTH-1:WIDTH]; end
            4'd1: begin rot = {a, a} >> sh; res = rot[WIDTH-1:0]; end
            4'd2: res = (a > b) ? a : b;
            4'd3: res = (a < b) ? a : b;
            4'd4: res = ~(a & b);
            4'd5: res = (a < b) ? WIDTH'(1) : '0;
            4'd6: res = a ^ b;
            default: res = '0;
        endcase
        return {res[WIDTH-1], (res == '0), ^res, res};
    endfunction

    assign {bus1.alu_overflow, bus1.alu_zero, bus1.alu_carry, bus1.alu_result} =
        alu_model(bus1.alu_opcode, bus1.alu_input1, bus1.alu_input2, bus1.alu_shiftValue);
    assign {bus4.alu_overflow, bus4.alu_zero, bus4.alu_carry, bus4.alu_result} =
        alu_model(bus4.alu_opcode, bus4.alu_input1, bus4.alu_input2, bus4.alu_shiftValue);

    // Expected response {err, flags, tag, result} for a command
    function automatic logic [WIDTH+7:0] exp_rsp(input cmd_t c);
        logic [WIDTH+2:0] m;
        if (c.opc > 4'd6) return {1'b1, 3'b000, c.tag, WIDTH'(0)};
        m = alu_model(c.opc, c.a, c.b, c.sh);
        return {1'b0, m[WIDTH+2:WIDTH], c.tag, m[WIDTH-1:0]};
    endfunction

    function automatic cmd_t rand_cmd(input logic [3:0] tag, input bit allow_illegal);
        cmd_t c;
        c.opc = allow_illegal ? 4'($urandom_range(15, 0)) : 4'($urandom_range(6, 0));
        c.a   = {$urandom, $urandom, $urandom, $urandom};
        c.b   = ($urandom_range(7, 0) == 0) ? c.a : {$urandom, $urandom, $urandom, $urandom};
        c.sh  = 5'($urandom_range(31, 0));
        c.tag = tag;
        return c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive1(input cmd_t c);
        bus1.cmd_valid  = 1'b1;
        bus1.cmd_opcode = c.opc;
        bus1.cmd_a      = c.a;
        bus1.cmd_b      = c.b;
        bus1.cmd_shift  = c.sh;
        bus1.cmd_tag    = c.tag;
    endtask

    task automatic drive4(input cmd_t c);
        bus4.cmd_valid  = 1'b1;
        bus4.cmd_opcode = c.opc;
        bus4.cmd_a      = c.a;
        bus4.cmd_b      = c.b;
        bus4.cmd_shift  = c.sh;
        bus4.cmd_tag    = c.tag;
    endtask

    task automatic note_legal(input cmd_t c);
        if (c.opc <= 4'd6) last1 = c;
    endtask

    task automatic clear_last();
        last1 = '{opc: 4'd0, a: '0, b: '0, sh: 5'd0, tag: 4'd0};
        exp_ops1 = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (bus1.cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_in_rst: got %b exp 0", bus1.cmd_ready); end
        rst = 1'b0;
        tick();
        clear_last();
        checks++;
        if ({bus1.rsp_valid, bus1.rsp_flags, bus1.rsp_tag, bus1.rsp_err, bus1.busy} !== 10'd0) begin
            errors++; $display("FAIL reset_ctrl: got %h exp 0", {bus1.rsp_valid, bus1.rsp_flags, bus1.rsp_tag, bus1.rsp_err, bus1.busy});
        end
        checks++;
        if (bus1.rsp_result !== '0) begin errors++; $display("FAIL reset_result: got %h exp 0", bus1.rsp_result); end
        checks++;
        if ({bus1.alu_opcode, bus1.alu_shiftValue, bus1.alu_input1, bus1.alu_input2} !== '0) begin
            errors++; $display("FAIL reset_alu: got %h/%h exp 0", bus1.alu_opcode, bus1.alu_input1);
        end
        checks++;
        if (bus1.ops_count !== 16'd0) begin errors++; $display("FAIL reset_ops: got %h exp 0", bus1.ops_count); end
        checks++;
        if (bus1.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b exp 1", bus1.cmd_ready); end
        checks++;
        if ({bus4.rsp_valid, bus4.busy, bus4.cmd_ready} !== 3'b001) begin
            errors++; $display("FAIL reset_dut4: got %b exp 001", {bus4.rsp_valid, bus4.busy, bus4.cmd_ready});
        end
    endtask

    task automatic test_single_xor();
        cmd_t c;
        c = '{opc: 4'd6, a: WIDTH'(16'hF0F0), b: WIDTH'(16'h0FF0), sh: 5'd0, tag: 4'd3};
        bus1.rsp_ready = 1'b1;
        drive1(c);
        checks++;
        if (bus1.cmd_ready !== 1'b1) begin errors++; $display("FAIL xor_accept: got %b exp 1", bus1.cmd_ready); end
        note_legal(c);
        tick();
        bus1.cmd_valid = 1'b0;
        checks++;
        if ({bus1.rsp_valid, bus1.busy} !== 2'b01) begin errors++; $display("FAIL xor_e0: got valid,busy=%b exp 01", {bus1.rsp_valid, bus1.busy}); end
        tick();
        checks++;
        if ({bus1.rsp_valid, bus1.alu_opcode, bus1.alu_input1} !== {1'b0, 4'd6, c.a}) begin
            errors++; $display("FAIL xor_e1: got valid=%b op=%h in1=%h exp 0/6/%h", bus1.rsp_valid, bus1.alu_opcode, bus1.alu_input1, c.a);
        end
        tick();
        checks++;
        if (bus1.rsp_valid !== 1'b1) begin errors++; $display("FAIL xor_latency: got valid=%b exp 1", bus1.rsp_valid); end
        checks++;
        if ({bus1.rsp_err, bus1.rsp_tag, bus1.rsp_result} !== {1'b0, 4'd3, WIDTH'(16'hFF00)}) begin
            errors++; $display("FAIL xor_rsp: got err=%b tag=%h res=%h exp 0/3/ff00", bus1.rsp_err, bus1.rsp_tag, bus1.rsp_result);
        end
        exp_ops1++;
        tick();
        checks++;
        if ({bus1.ops_count, bus1.rsp_valid, bus1.busy} !== {16'd1, 2'b00}) begin
            errors++; $display("FAIL xor_after: got ops=%h valid=%b busy=%b exp 1/0/0", bus1.ops_count, bus1.rsp_valid, bus1.busy);
        end
    endtask

    task automatic test_fifo_fill();
        cmd_t q[$];
        cmd_t c;
        int   got = 0;
        bus1.rsp_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            c = rand_cmd(4'(i), 1'b0);
            drive1(c);
            checks++;
            if (bus1.cmd_ready !== ((i < 5) ? 1'b1 : 1'b0)) begin
                errors++; $display("FAIL fill_ready[%0d]: got %b exp %b", i, bus1.cmd_ready, (i < 5));
            end
            if (bus1.cmd_ready) begin q.push_back(c); note_legal(c); end
            tick();
        end
        bus1.cmd_valid = 1'b0;
        bus1.rsp_ready = 1'b1;
        for (int cyc = 0; cyc < 100 && got < 5; cyc++) begin
            if (bus1.rsp_valid) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL fill_spurious: got tag %h exp none", bus1.rsp_tag);
                end else begin
                    c = q.pop_front();
                    if ({bus1.rsp_err, bus1.rsp_flags, bus1.rsp_tag, bus1.rsp_result} !== exp_rsp(c)) begin
                        errors++; $display("FAIL fill_order[%0d]: got %h exp %h", got,
                                           {bus1.rsp_err, bus1.rsp_flags, bus1.rsp_tag, bus1.rsp_result}, exp_rsp(c));
                    end
                end
                got++;
                exp_ops1++;
            end
            tick();
        end
        checks++;
        if (got != 5) begin errors++; $display("FAIL fill_timeout: got %0d responses exp 5", got); end
    endtask

    task automatic test_back_to_back();
        cmd_t q[$];
        cmd_t c;
        int   sent = 0;
        int   got = 0;
        int   last_cyc = 0;
        bus1.rsp_ready = 1'b1;
        for (int cyc = 0; cyc < 100 && got < 4; cyc++) begin
            if (sent < 4) begin c = rand_cmd(4'(sent + 8), 1'b0); drive1(c); end
            else bus1.cmd_valid = 1'b0;
            if (bus1.cmd_valid && bus1.cmd_ready) begin q.push_back(c); note_legal(c); sent++; end
            if (bus1.rsp_valid) begin
                checks++;
                if (q.size() == 0 || {bus1.rsp_err, bus1.rsp_flags, bus1.rsp_tag, bus1.rsp_result} !== exp_rsp(q[0])) begin
                    errors++; $display("FAIL b2b_rsp[%0d]: got tag %h res %h", got, bus1.rsp_tag, bus1.rsp_result);
                end
                if (q.size() != 0) c = q.pop_front();
                if (got > 0) begin
                    checks++;
                    if (cyc - last_cyc != 2) begin errors++; $display("FAIL b2b_spacing: got %0d exp 2", cyc - last_cyc); end
                end
                last_cyc = cyc;
                got++;
                exp_ops1++;
            end
            tick();
        end
        bus1.cmd_valid = 1'b0;
        checks++;
        if (got != 4) begin errors++; $display("FAIL b2b_timeout: got %0d responses exp 4", got); end
    endtask

    task automatic test_random();
        cmd_t                q[$];
        cmd_t                c;
        int                  sent = 0;
        int                  got = 0;
        logic                stalled = 1'b0;
        logic [WIDTH+7:0]    held = '0;
        logic [WIDTH+7:0]    obs;
        for (int cyc = 0; cyc < 4000 && got < 60; cyc++) begin
            obs = {bus1.rsp_err, bus1.rsp_flags, bus1.rsp_tag, bus1.rsp_result};
            if (stalled) begin
                checks++;
                if (bus1.rsp_valid !== 1'b1 || obs !== held) begin
                    errors++; $display("FAIL rand_hold: got valid=%b %h exp 1 %h", bus1.rsp_valid, obs, held);
                end
            end
            if (sent < 60 && $urandom_range(3, 0) != 0) begin
                c = rand_cmd(4'($urandom_range(15, 0)), 1'b1);
                drive1(c);
            end else begin
                bus1.cmd_valid = 1'b0;
            end
            bus1.rsp_ready = ($urandom_range(3, 0) != 0);
            if (bus1.cmd_valid && bus1.cmd_ready) begin q.push_back(c); note_legal(c); sent++; end
            stalled = 1'b0;
            if (bus1.rsp_valid) begin
                if (bus1.rsp_ready) begin
                    checks++;
                    if (q.size() == 0) begin
                        errors++; $display("FAIL rand_spurious: got %h exp none", obs);
                    end else begin
                        c = q.pop_front();
                        if (obs !== exp_rsp(c)) begin errors++; $display("FAIL rand_rsp[%0d]: got %h exp %h", got, obs, exp_rsp(c)); end
                    end
                    got++;
                    exp_ops1++;
                end else begin
                    stalled = 1'b1;
                    held    = obs;
                end
            end
            tick();
        end
        bus1.cmd_valid = 1'b0;
        bus1.rsp_ready = 1'b1;
        checks++;
        if (got != 60) begin errors++; $display("FAIL rand_timeout: got %0d responses exp 60", got); end
        tick();
        checks++;
        if ({bus1.ops_count, bus1.busy} !== {16'(exp_ops1), 1'b0}) begin
            errors++; $display("FAIL rand_ops: got %h busy=%b exp %h busy=0", bus1.ops_count, bus1.busy, exp_ops1);
        end
    endtask

    task automatic test_illegal();
        cmd_t c;
        c = '{opc: 4'd9, a: {$urandom, $urandom, $urandom, $urandom}, b: '1, sh: 5'd7, tag: 4'd7};
        bus1.rsp_ready = 1'b1;
        drive1(c);
        tick();
        bus1.cmd_valid = 1'b0;
        checks++;
        if (bus1.rsp_valid !== 1'b0) begin errors++; $display("FAIL ill_early: got valid=%b exp 0", bus1.rsp_valid); end
        tick();
        checks++;
        if ({bus1.rsp_valid, bus1.rsp_err, bus1.rsp_flags, bus1.rsp_tag, bus1.rsp_result} !== {2'b11, 3'b000, 4'd7, WIDTH'(0)}) begin
            errors++; $display("FAIL ill_rsp: got v=%b err=%b fl=%b tag=%h res=%h exp 1/1/0/7/0",
                               bus1.rsp_valid, bus1.rsp_err, bus1.rsp_flags, bus1.rsp_tag, bus1.rsp_result);
        end
        checks++;
        if ({bus1.alu_opcode, bus1.alu_input1, bus1.alu_input2, bus1.alu_shiftValue} !== {last1.opc, last1.a, last1.b, last1.sh}) begin
            errors++; $display("FAIL ill_alu_kept: got op=%h in1=%h exp op=%h in1=%h", bus1.alu_opcode, bus1.alu_input1, last1.opc, last1.a);
        end
        exp_ops1++;
        tick();
        checks++;
        if (bus1.ops_count !== 16'(exp_ops1)) begin errors++; $display("FAIL ill_ops: got %h exp %h", bus1.ops_count, exp_ops1); end
    endtask

    task automatic test_settle4();
        cmd_t c;
        c = '{opc: 4'd0, a: WIDTH'(1), b: {$urandom, $urandom, $urandom, $urandom}, sh: 5'd5, tag: 4'd2};
        bus4.rsp_ready = 1'b1;
        drive4(c);
        tick();
        bus4.cmd_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            checks++;
            if ({bus4.rsp_valid, bus4.alu_opcode, bus4.alu_input1, bus4.alu_input2, bus4.alu_shiftValue} !== {1'b0, c.opc, c.a, c.b, c.sh}) begin
                errors++; $display("FAIL s4_hold[%0d]: got v=%b op=%h in1=%h sh=%h exp 0/0/1/5", k,
                                   bus4.rsp_valid, bus4.alu_opcode, bus4.alu_input1, bus4.alu_shiftValue);
            end
        end
        tick();
        checks++;
        if ({bus4.rsp_valid, bus4.rsp_err, bus4.rsp_flags, bus4.rsp_tag, bus4.rsp_result} !== {1'b1, exp_rsp(c)}) begin
            errors++; $display("FAIL s4_rsp: got v=%b res=%h tag=%h fl=%b exp 1 %h", bus4.rsp_valid, bus4.rsp_result, bus4.rsp_tag, bus4.rsp_flags, exp_rsp(c));
        end
        checks++;
        if (bus4.rsp_result !== WIDTH'(32'h20)) begin errors++; $display("FAIL s4_result: got %h exp 20", bus4.rsp_result); end
        tick();
        checks++;
        if ({bus4.ops_count, bus4.rsp_valid} !== {16'd1, 1'b0}) begin
            errors++; $display("FAIL s4_ops: got %h v=%b exp 1/0", bus4.ops_count, bus4.rsp_valid);
        end
    endtask

    task automatic test_reset_mid();
        cmd_t c;
        bus4.rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            c = rand_cmd(4'(i), 1'b0);
            drive4(c);
            tick();
        end
        bus4.cmd_valid = 1'b0;
        checks++;
        if ({bus4.busy, bus4.rsp_valid} !== 2'b10) begin errors++; $display("FAIL rm_pre: got busy,valid=%b exp 10", {bus4.busy, bus4.rsp_valid}); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_last();
        #1;
        checks++;
        if ({bus4.rsp_valid, bus4.busy, bus4.ops_count, bus4.cmd_ready} !== {2'b00, 16'd0, 1'b1}) begin
            errors++; $display("FAIL rm_after: got v=%b busy=%b ops=%h rdy=%b exp 0/0/0/1", bus4.rsp_valid, bus4.busy, bus4.ops_count, bus4.cmd_ready);
        end
        for (int k = 0; k < 8; k++) begin
            tick();
            checks++;
            if ({bus4.rsp_valid, bus4.busy} !== 2'b00) begin
                errors++; $display("FAIL rm_empty[%0d]: got valid,busy=%b exp 00", k, {bus4.rsp_valid, bus4.busy});
            end
        end
    endtask

    task automatic test_wrap();
        int   pushes = 0;
        int   hs = 0;
        logic seen = 1'b0;
        bus1.cmd_opcode = 4'hF;
        bus1.cmd_tag    = 4'($urandom_range(15, 0));
        bus1.rsp_ready  = 1'b1;
        for (int cyc = 0; cyc < 70000 && hs < 65536; cyc++) begin
            bus1.cmd_valid = (pushes < 65536);
            if (bus1.cmd_valid && bus1.cmd_ready) pushes++;
            if (bus1.rsp_valid) hs++;
            tick();
            if (hs == 65535 && !seen) begin
                seen = 1'b1;
                checks++;
                if (bus1.ops_count !== 16'hFFFF) begin errors++; $display("FAIL wrap_ffff: got %h exp ffff", bus1.ops_count); end
            end
        end
        bus1.cmd_valid = 1'b0;
        checks++;
        if (hs != 65536) begin errors++; $display("FAIL wrap_timeout: got %0d handshakes exp 65536", hs); end
        checks++;
        if (bus1.ops_count !== 16'd0) begin errors++; $display("FAIL wrap_zero: got %h exp 0", bus1.ops_count); end
        tick();
    endtask

    initial begin
        bus1.cmd_valid = 1'b0; bus1.cmd_opcode = '0; bus1.cmd_a = '0; bus1.cmd_b = '0;
        bus1.cmd_shift = '0;   bus1.cmd_tag = '0;    bus1.rsp_ready = 1'b1;
        bus4.cmd_valid = 1'b0; bus4.cmd_opcode = '0; bus4.cmd_a = '0; bus4.cmd_b = '0;
        bus4.cmd_shift = '0;   bus4.cmd_tag = '0;    bus4.rsp_ready = 1'b1;
        clear_last();
        test_reset();
        test_single_xor();
        test_fifo_fill();
        test_back_to_back();
        test_random();
        test_illegal();
        test_settle4();
        test_reset_mid();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
